debounce_strobe: RTL and testbench
==================================

DEBOUNCE_STROBE -- requirements
Module: debounce_strobe

Interface
REQ-001 Parameter: STABLE_CYCLES, default 4, consecutive synchronized samples that must disagree with d before d updates; legal range 2..65535.
REQ-002 Parameter: SYNC_STAGES, default 2, depth of the input synchronizer; legal range 2..4.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: din  input  1  raw asynchronous level (switch/button), may bounce.
REQ-006 Port: d  output  1  debounced level; feeds the downstream flip-flop data input.
REQ-007 Port: en  output  1  one-cycle strobe, high in the cycle d takes a new value; feeds the downstream flip-flop enable.
REQ-008 Port: rise  output  1  one-cycle strobe when d goes 0->1.
REQ-009 Port: fall  output  1  one-cycle strobe when d goes 1->0.
REQ-010 Port: busy  output  1  high while a candidate change is being qualified.

Function
REQ-011 din SHALL pass through a SYNC_STAGES-deep flop chain; its last stage is the sampled signal s; no other logic shall read din.
REQ-012 The FSM SHALL have four states: IDLE_LO, CHK_HI, IDLE_HI, CHK_LO.
REQ-013 IDLE_LO: s=1 -> CHK_HI with cnt=1; else hold. IDLE_HI: s=0 -> CHK_LO with cnt=1; else hold.
REQ-014 CHK_x with s still != d and cnt < STABLE_CYCLES-1: cnt increments, state held.
REQ-015 CHK_x with s still != d and cnt = STABLE_CYCLES-1: d toggles, cnt=0, state -> opposite IDLE (commit edge).
REQ-016 CHK_x with s = d (bounce): return to IDLE of current d, cnt=0, d unchanged, no strobe.
REQ-017 en, rise, fall SHALL be registered and high exactly in the cycle after the commit edge, i.e. coincident with the new d value, and low otherwise.
REQ-018 rise and fall SHALL never be high together; en = rise OR fall at all times.
REQ-019 busy SHALL be high exactly when state is CHK_HI or CHK_LO.
REQ-020 Latency: counting the first rising edge that samples a stable new din as edge 1, d and en SHALL change on edge SYNC_STAGES+STABLE_CYCLES (edge 6 with defaults).
REQ-021 Minimum spacing between two en strobes SHALL be STABLE_CYCLES cycles; strobes SHALL never occur on consecutive cycles.
REQ-022 cnt width SHALL be clog2(STABLE_CYCLES); cnt SHALL never wrap and never exceed STABLE_CYCLES-1.
REQ-023 Any din pulse shorter than STABLE_CYCLES cycles (after synchronization) SHALL produce no change on d, en, rise, fall.

Reset
REQ-024 While reset is high: d=0, en=0, rise=0, fall=0, busy=0, all synchronizer flops=0, cnt=0, state=IDLE_LO, asynchronously and without needing a clock.
REQ-025 Reset asserted mid-qualification SHALL abort the qualification with no strobe; after release, qualification restarts from synchronizer fill.
REQ-026 If din is high at reset release, d SHALL reach 1 with one rise/en strobe per REQ-020, counting the first edge after release as edge 1.

Structure
REQ-027 Package debounce_pkg SHALL hold the state enum type and default STABLE_CYCLES/SYNC_STAGES constants.
REQ-028 The synchronizer SHALL be a separate sub-module sync_chain (parameter STAGES, ports clk, reset, a, y), reset to 0.
REQ-029 FSM, counter and strobe registers SHALL live in debounce_strobe; no combinational path from din to any output.

Verification (defaults STABLE_CYCLES=4, SYNC_STAGES=2, 10-unit clock)
REQ-030 Reset held 20 units with din=1, released -> all outputs 0 during reset; d=1 with en=rise=1 for one cycle on the 6th edge after release.
REQ-031 Clean 0->1 step on din held 10 cycles -> busy high for 3 cycles, then d=1, en=rise=1 for one cycle on edge 6, fall=0.
REQ-032 din bounces 1,0,1,0 (one cycle each) then holds 1 -> no strobe during bounce; single en/rise at edge 6 after the final stable 1 is first sampled.
REQ-033 din 1-cycle and 3-cycle glitches from a settled 0 -> d stays 0, en/rise/fall never assert, busy returns to 0.
REQ-034 Reset asserted at the 2nd cycle busy is high during a 0->1 qualification -> outputs 0 immediately, no strobe; with din still 1, fresh qualification completes 6 edges after release.
REQ-035 Settled d=1, din steps 1->0 -> d=0 with en=fall=1 for one cycle on edge 6; rise stays 0.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and default parameters for the debounced strobe generator.
package debounce_pkg;

    localparam int DEFAULT_STABLE_CYCLES = 4;
    localparam int DEFAULT_SYNC_STAGES   = 2;

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        CHK_HI  = 2'd1,
        IDLE_HI = 2'd2,
        CHK_LO  = 2'd3
    } state_t;

endpackage

// File: rtl/debounce_strobe_sync_chain.sv
// Multi-flop synchronizer for an asynchronous level; all stages clear to 0 on reset.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic a,
    output logic y
);

    logic [STAGES-1:0] sync_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_reg[0] <= 1'b0;
        end else begin
            sync_reg[0] <= a;
        end
    end

    generate
        for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sync_reg[gi] <= 1'b0;
                end else begin
                    sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign y = sync_reg[STAGES-1];

endmodule

// File: rtl/debounce_strobe.sv
// Debounces a raw switch level and emits registered d/en/rise/fall strobes
// suitable for driving a downstream enabled flip-flop.
module debounce_strobe
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic d,
    output logic en,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int                CNT_W    = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             d_reg;
    logic             en_reg;
    logic             rise_reg;
    logic             fall_reg;
    logic             busy_reg;
    logic             s;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .a     (din),
        .y     (s)
    );

    // Strobes default low every cycle; only the commit edge raises them,
    // so they land in the same cycle as the new d value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE_LO;
            cnt_reg   <= '0;
            d_reg     <= 1'b0;
            en_reg    <= 1'b0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            en_reg   <= 1'b0;
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
            case (state_reg)
                IDLE_LO: begin
                    if (s) begin
                        state_reg <= CHK_HI;
                        cnt_reg   <= CNT_ONE;
                        busy_reg  <= 1'b1;
                    end
                end
                IDLE_HI: begin
                    if (!s) begin
                        state_reg <= CHK_LO;
                        cnt_reg   <= CNT_ONE;
                        busy_reg  <= 1'b1;
                    end
                end
                CHK_HI, CHK_LO: begin
                    if (s == d_reg) begin
                        // Bounced back before qualifying: drop the candidate.
                        state_reg <= d_reg ? IDLE_HI : IDLE_LO;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b0;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg <= s ? IDLE_HI : IDLE_LO;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b0;
                        d_reg     <= s;
                        en_reg    <= 1'b1;
                        rise_reg  <= s;
                        fall_reg  <= !s;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end
                default: begin
                    state_reg <= IDLE_LO;
                    cnt_reg   <= '0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign d    = d_reg;
    assign en   = en_reg;
    assign rise = rise_reg;
    assign fall = fall_reg;
    assign busy = busy_reg;

endmodule

// File: tb/tb_debounce_strobe.sv
// Directed scoreboard bench for debounce_strobe at default parameters.
module tb_debounce_strobe;

    localparam int SYNC   = 2;
    localparam int STABLE = 4;
    localparam int COMMIT = SYNC + STABLE;

    typedef struct packed {
        logic d;
        logic en;
        logic rise;
        logic fall;
        logic busy;
    } obs_t;

    logic clk = 1'b0;
    logic reset;
    logic din;
    logic d, en, rise, fall, busy;

    int tests  = 0;
    int failed = 0;

    obs_t  exp_q[$];
    string tag_q[$];

    debounce_strobe #(
        .STABLE_CYCLES (STABLE),
        .SYNC_STAGES   (SYNC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .d     (d),
        .en    (en),
        .rise  (rise),
        .fall  (fall),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(input logic dv, input logic env, input logic rv,
                                input logic fv, input logic bv);
        return obs_t'({dv, env, rv, fv, bv});
    endfunction

    // Expected outputs k edges after a stable new level nv is first sampled.
    function automatic obs_t qual_exp(input int k, input logic nv);
        logic bsy, cmt, dv;
        bsy = (k >= SYNC + 1) && (k < COMMIT);
        cmt = (k == COMMIT);
        dv  = (k >= COMMIT) ? nv : !nv;
        return mk(dv, cmt, cmt && nv, cmt && !nv, bsy);
    endfunction

    task automatic compare_front();
        obs_t  e, got;
        string t;
        e   = exp_q.pop_front();
        t   = tag_q.pop_front();
        got = obs_t'({d, en, rise, fall, busy});
        tests++;
        assert (got === e) else begin
            failed++;
            $error("FAIL %s: d/en/rise/fall/busy observed %b expected %b", t, got, e);
        end
    endtask

    task automatic drive(input logic v, input obs_t e, input string tag);
        din = v;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        compare_front();
    endtask

    task automatic check_now(input obs_t e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        compare_front();
    endtask

    task automatic qualify(input logic nv, input string name);
        for (int k = 1; k <= COMMIT + 4; k++)
            drive(nv, qual_exp(k, nv), $sformatf("%s[%0d]", name, k));
    endtask

    // Strobe consistency holds on every cycle outside reset.
    always @(negedge clk) begin
        if (!reset) begin
            tests++;
            assert (!(rise && fall) && (en === (rise | fall))) else begin
                failed++;
                $error("FAIL strobe_invariant: en/rise/fall observed %b%b%b expected en=rise|fall, not both",
                       en, rise, fall);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        din   = 1'b1;
        #1;
        check_now(mk(0, 0, 0, 0, 0), "reset_async");
        @(posedge clk); #1;
        check_now(mk(0, 0, 0, 0, 0), "reset_hold1");
        @(posedge clk); #1;
        check_now(mk(0, 0, 0, 0, 0), "reset_hold2");
        #4 reset = 1'b0;
        qualify(1'b1, "rst_release_rise");

        qualify(1'b0, "fall_step");

        for (int len = 1; len <= 3; len++)
            for (int k = 1; k <= 9; k++)
                drive(k <= len, mk(0, 0, 0, 0, (k >= 3) && (k <= len + 2)),
                      $sformatf("glitch%0d[%0d]", len, k));

        qualify(1'b1, "rise_step");
        qualify(1'b0, "fall_step2");

        for (int k = 1; k <= 14; k++) begin
            logic v, b, c;
            v = (k == 1) || (k == 3) || (k >= 5);
            b = (k == 3) || (k == 5) || (k == 7) || (k == 8) || (k == 9);
            c = (k == 10);
            drive(v, mk(k >= 10, c, c, 0, b), $sformatf("bounce[%0d]", k));
        end

        qualify(1'b0, "fall_step3");

        for (int k = 1; k <= SYNC + 2; k++)
            drive(1'b1, qual_exp(k, 1'b1), $sformatf("pre_abort[%0d]", k));
        reset = 1'b1;
        #1;
        check_now(mk(0, 0, 0, 0, 0), "abort_async");
        @(posedge clk); #1;
        check_now(mk(0, 0, 0, 0, 0), "abort_hold");
        reset = 1'b0;
        qualify(1'b1, "after_abort");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
